// File: rtl/led_pkg.sv
// led_pkg: shared LED mode/direction encodings for LED and display blocks
package led_pkg;
  localparam logic [1:0] MODE_ROTL  = 2'd0;
  localparam logic [1:0] MODE_ROTR  = 2'd1;
  localparam logic [1:0] MODE_PING  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;
  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: step tick divider, period (DIV_MAX >> speed) + 1 cycles
// ports: sys_clk, sys_rst_n (async low) | en freezes cnt, speed selects terminal,
//        clr restarts the period | tick high on the cycle cnt reaches terminal while enabled
module led_tick_gen #(
  parameter int DIV_MAX = 10_000_000,
  parameter int CNT_W   = 24
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  input  logic [1:0] speed,
  input  logic       clr,
  output logic       tick
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  assign term = CNT_W'(DIV_MAX) >> speed;
  // >= so a shrinking terminal steps at once instead of wrapping through the counter
  assign tick = en && (cnt >= term);
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: N-LED pattern engine with rotate, ping-pong and blink modes
// ports: sys_clk, sys_rst_n (async low) | en run/freeze, mode pattern select,
//        speed period divisor | led registered drive, step_pulse one cycle per step
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int LED_NUM = 4,
  parameter int DIV_MAX = 10_000_000,
  parameter int CNT_W   = 24
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  output logic [LED_NUM-1:0] led,
  output logic               step_pulse
);
  logic [1:0]         mode_q;
  dir_t               dir;
  dir_t               dir_nxt;
  logic               tick;
  logic               chg;
  logic               step;
  logic [LED_NUM-1:0] nxt;
  logic [LED_NUM-1:0] init;
  assign chg  = mode != mode_q;
  assign step = tick && !chg;
  assign init = (mode == MODE_BLINK) ? '0 : LED_NUM'(1);
  led_tick_gen #(.DIV_MAX(DIV_MAX), .CNT_W(CNT_W)) u_tick (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .speed(speed), .clr(chg), .tick(tick)
  );
  always_comb begin
    nxt = (mode_q == MODE_ROTL) ? {led[LED_NUM-2:0], led[LED_NUM-1]} :
          (mode_q == MODE_ROTR) ? {led[0], led[LED_NUM-1:1]} :
          (mode_q == MODE_PING) ? ((dir == DIR_LEFT) ? led << 1 : led >> 1) : ~led;
    // ping-pong turns around on reaching an end so the end LED is lit only once
    dir_nxt = (mode_q != MODE_PING) ? dir :
              nxt[LED_NUM-1] ? DIR_RIGHT : nxt[0] ? DIR_LEFT : dir;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      mode_q     <= MODE_ROTL;
      dir        <= DIR_LEFT;
      led        <= LED_NUM'(1);
      step_pulse <= 1'b0;
    end else begin
      mode_q     <= mode;
      step_pulse <= step;
      if (chg) begin
        led <= init;
        dir <= DIR_LEFT;
      end else if (step) begin
        led <= nxt;
        dir <= dir_nxt;
      end
    end
endmodule
